// File: rtl/noc_axi4_bridge_ser_pkg.sv
// Shared noc_axi4 bridge definitions: widths, MSG_LENGTH field position, serializer states
// and the 64-bit byte-swap helper also used by the deserializer.
package noc_axi4_bridge_ser_pkg;

    localparam int NOC_DATA_WIDTH   = 64;
    localparam int AXI4_DATA_WIDTH  = 512;
    localparam int PAYLOAD_LEN      = AXI4_DATA_WIDTH / NOC_DATA_WIDTH;
    localparam int MAX_HDR_FLITS    = 3;
    localparam int MSG_HEADER_WIDTH = MAX_HDR_FLITS * NOC_DATA_WIDTH;
    localparam int MSG_LENGTH_LO    = 22;
    localparam int MSG_LENGTH_WIDTH = 8;
    // One extra bit so that MSG_LENGTH+1 never wraps at the top of the field.
    localparam int CNT_WIDTH        = MSG_LENGTH_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND_HDR,
        SEND_DATA
    } serState_e;

    function automatic logic [NOC_DATA_WIDTH-1:0] byteSwap64(input logic [NOC_DATA_WIDTH-1:0] word);
        logic [NOC_DATA_WIDTH-1:0] swapped;
        for (int b = 0; b < NOC_DATA_WIDTH / 8; b++) begin
            swapped[b*8 +: 8] = word[(NOC_DATA_WIDTH/8 - 1 - b)*8 +: 8];
        end
        return swapped;
    endfunction

endpackage

// File: rtl/noc_axi4_bridge_ser_if.sv
// Message-in / flit-out handshake bundle of the noc_axi4 bridge serializer.
interface noc_axi4_bridge_ser_if;
    import noc_axi4_bridge_ser_pkg::*;

    logic [MSG_HEADER_WIDTH-1:0] header_in;
    logic [AXI4_DATA_WIDTH-1:0]  data_in;
    logic                        in_val;
    logic                        in_rdy;
    logic [NOC_DATA_WIDTH-1:0]   flit_out;
    logic                        flit_out_val;
    logic                        flit_out_rdy;

    modport master (
        output header_in, data_in, in_val, flit_out_rdy,
        input  in_rdy, flit_out, flit_out_val
    );

    modport slave (
        input  header_in, data_in, in_val, flit_out_rdy,
        output in_rdy, flit_out, flit_out_val
    );

endinterface

// File: rtl/noc_axi4_bridge_ser.sv
// Serializes one header + AXI data beat into NoC flits under valid/ready.
// Define NOC_AXI4_SER_SWAP_EN to byte-reverse every data flit (header flits untouched).
module noc_axi4_bridge_ser
    import noc_axi4_bridge_ser_pkg::*;
#(
    parameter int HDR_FLITS         = 1,
    parameter int AXI2NOC_SER_ORDER = 0
) (
    input logic                  clk,
    input logic                  rst,
    noc_axi4_bridge_ser_if.slave bus
);

    localparam int HIDX_W = 2;
    localparam int DIDX_W = $clog2(PAYLOAD_LEN);

    serState_e                   state_q;
    logic [HIDX_W-1:0]           idx_q;
    logic [DIDX_W-1:0]           didx_q;
    logic [CNT_WIDTH-1:0]        hdrCnt_q;
    logic [CNT_WIDTH-1:0]        datCnt_q;
    logic [MSG_HEADER_WIDTH-1:0] header_q;
    logic [AXI4_DATA_WIDTH-1:0]  data_q;

    logic [CNT_WIDTH-1:0]        total;
    logic [CNT_WIDTH-1:0]        remain;
    logic [CNT_WIDTH-1:0]        hdrCnt_d;
    logic [CNT_WIDTH-1:0]        datCnt_d;

    logic [NOC_DATA_WIDTH-1:0]   hdrWords [MAX_HDR_FLITS];
    logic [NOC_DATA_WIDTH-1:0]   dataWords [PAYLOAD_LEN];
    logic [DIDX_W-1:0]           dataSel;
    logic [NOC_DATA_WIDTH-1:0]   dataFlit;
    logic [NOC_DATA_WIDTH-1:0]   flitOut;

    // Flit budget of the incoming message; over-long messages are clipped to one beat of data.
    always_comb begin
        total    = CNT_WIDTH'(bus.header_in[MSG_LENGTH_LO +: MSG_LENGTH_WIDTH]) + CNT_WIDTH'(1);
        hdrCnt_d = (total < CNT_WIDTH'(HDR_FLITS)) ? total : CNT_WIDTH'(HDR_FLITS);
        remain   = total - hdrCnt_d;
        datCnt_d = (remain < CNT_WIDTH'(PAYLOAD_LEN)) ? remain : CNT_WIDTH'(PAYLOAD_LEN);
    end

    always_comb begin
        for (int k = 0; k < MAX_HDR_FLITS; k++) begin
            hdrWords[k] = header_q[k*NOC_DATA_WIDTH +: NOC_DATA_WIDTH];
        end
        for (int k = 0; k < PAYLOAD_LEN; k++) begin
            dataWords[k] = data_q[k*NOC_DATA_WIDTH +: NOC_DATA_WIDTH];
        end
        dataSel = (AXI2NOC_SER_ORDER != 0) ? didx_q : DIDX_W'(PAYLOAD_LEN - 1) - didx_q;
`ifdef NOC_AXI4_SER_SWAP_EN
        dataFlit = byteSwap64(dataWords[dataSel]);
`else
        dataFlit = dataWords[dataSel];
`endif
        case (state_q)
            SEND_HDR:  flitOut = hdrWords[idx_q];
            SEND_DATA: flitOut = dataFlit;
            default:   flitOut = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            didx_q   <= '0;
            hdrCnt_q <= '0;
            datCnt_q <= '0;
            header_q <= '0;
            data_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_val) begin
                        header_q <= bus.header_in;
                        data_q   <= bus.data_in;
                        hdrCnt_q <= hdrCnt_d;
                        datCnt_q <= datCnt_d;
                        idx_q    <= '0;
                        didx_q   <= '0;
                        state_q  <= SEND_HDR;
                    end
                end
                SEND_HDR: begin
                    if (bus.flit_out_rdy) begin
                        if (CNT_WIDTH'(idx_q) == hdrCnt_q - CNT_WIDTH'(1)) begin
                            idx_q   <= '0;
                            state_q <= (datCnt_q != '0) ? SEND_DATA : IDLE;
                        end else begin
                            idx_q <= idx_q + HIDX_W'(1);
                        end
                    end
                end
                SEND_DATA: begin
                    if (bus.flit_out_rdy) begin
                        if (CNT_WIDTH'(didx_q) == datCnt_q - CNT_WIDTH'(1)) begin
                            didx_q  <= '0;
                            state_q <= IDLE;
                        end else begin
                            didx_q <= didx_q + DIDX_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_rdy       = (state_q == IDLE) & ~rst;
    assign bus.flit_out_val = (state_q != IDLE);
    assign bus.flit_out     = flitOut;

endmodule

// File: tb/tb_noc_axi4_bridge_ser.sv
// Bench for noc_axi4_bridge_ser: two instances (1 header/MSB-first and 2 headers/LSB-first)
// fed the same messages, each checked against a flit-list model of the message rules.
module tb_noc_axi4_bridge_ser;
    import noc_axi4_bridge_ser_pkg::*;

    localparam int NW = NOC_DATA_WIDTH;
    typedef logic [NW-1:0] word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [MSG_HEADER_WIDTH-1:0] hdrIn = '0;
    logic [AXI4_DATA_WIDTH-1:0]  dataIn = '0;
    logic inVal = 1'b0;
    logic flitRdy = 1'b1;
    int   bpMode = 0;

    int testCnt = 0;
    int failCnt = 0;
    int cyc = 0;

    logic [MSG_HEADER_WIDTH-1:0] curHdr;
    logic [AXI4_DATA_WIDTH-1:0]  curData;
    word_t expQ[$];
    word_t got0[$];
    word_t got1[$];
    int    stamp0[$];
    int    n0;
    word_t held0, held1;
    logic  heldV0 = 1'b0, heldV1 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    noc_axi4_bridge_ser_if if0();
    noc_axi4_bridge_ser_if if1();

    assign if0.header_in = hdrIn;   assign if1.header_in = hdrIn;
    assign if0.data_in = dataIn;    assign if1.data_in = dataIn;
    assign if0.in_val = inVal;      assign if1.in_val = inVal;
    assign if0.flit_out_rdy = flitRdy;
    assign if1.flit_out_rdy = flitRdy;

    noc_axi4_bridge_ser #(.HDR_FLITS(1), .AXI2NOC_SER_ORDER(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    noc_axi4_bridge_ser #(.HDR_FLITS(2), .AXI2NOC_SER_ORDER(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    // Consumer readiness: always ready, 1010 toggling, or random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (bpMode)
                0:       flitRdy = 1'b1;
                1:       flitRdy = ~flitRdy;
                default: flitRdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Flit capture plus the hold-while-stalled check, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && if0.flit_out_val) begin
            if (heldV0) begin
                testCnt++;
                assert (if0.flit_out === held0) else begin
                    failCnt++;
                    $error("[TB] FAIL stable0 observed %h expected %h", if0.flit_out, held0);
                end
            end
            if (if0.flit_out_rdy) begin
                got0.push_back(if0.flit_out);
                stamp0.push_back(cyc);
                heldV0 = 1'b0;
            end else begin
                held0  = if0.flit_out;
                heldV0 = 1'b1;
            end
        end else begin
            heldV0 = 1'b0;
        end
        if (!rst && if1.flit_out_val) begin
            if (heldV1) begin
                testCnt++;
                assert (if1.flit_out === held1) else begin
                    failCnt++;
                    $error("[TB] FAIL stable1 observed %h expected %h", if1.flit_out, held1);
                end
            end
            if (if1.flit_out_rdy) begin
                got1.push_back(if1.flit_out);
                heldV1 = 1'b0;
            end else begin
                held1  = if1.flit_out;
                heldV1 = 1'b1;
            end
        end else begin
            heldV1 = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [NW-1:0] observed, input logic [NW-1:0] expected);
        testCnt++;
        assert (observed === expected) else begin
            failCnt++;
            $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic setMode(input int m);
        bpMode = m;
        tick();
        tick();
    endtask

    // Expected flit list: leading header words, then clipped payload words in the chosen order.
    task automatic buildExp(input int hf, input int ord);
        int len, total, nh, nd, w;
        word_t word;
        expQ.delete();
        len   = int'(curHdr[MSG_LENGTH_LO +: MSG_LENGTH_WIDTH]);
        total = len + 1;
        nh    = (total < hf) ? total : hf;
        nd    = total - nh;
        if (nd > PAYLOAD_LEN) nd = PAYLOAD_LEN;
        for (int i = 0; i < nh; i++) expQ.push_back(curHdr[i*NW +: NW]);
        for (int k = 0; k < nd; k++) begin
            w    = (ord != 0) ? k : PAYLOAD_LEN - 1 - k;
            word = curData[w*NW +: NW];
`ifdef NOC_AXI4_SER_SWAP_EN
            word = {<<8{word}};
`endif
            expQ.push_back(word);
        end
    endtask

    task automatic checkOutput(input string tag, input int which);
        word_t g[$];
        word_t obs;
        if (which == 0) begin
            buildExp(1, 0);
            g = got0;
        end else begin
            buildExp(2, 1);
            g = got1;
        end
        check({tag, "_count"}, NW'(g.size()), NW'(expQ.size()));
        for (int i = 0; i < expQ.size(); i++) begin
            obs = (i < g.size()) ? g[i] : 'x;
            check($sformatf("%s_flit%0d", tag, i), obs, expQ[i]);
        end
    endtask

    task automatic loadMsg(input int len, input logic [AXI4_DATA_WIDTH-1:0] data);
        for (int i = 0; i < MSG_HEADER_WIDTH / 32; i++) curHdr[i*32 +: 32] = $urandom();
        curHdr[MSG_LENGTH_LO +: MSG_LENGTH_WIDTH] = MSG_LENGTH_WIDTH'(len);
        curData = data;
        hdrIn   = curHdr;
        dataIn  = curData;
        got0.delete();
        got1.delete();
        stamp0.delete();
    endtask

    // Hands one message to both (idle) instances and waits until both are idle again.
    task automatic applyStimulus(input int len, input logic [AXI4_DATA_WIDTH-1:0] data);
        logic bothIdle;
        loadMsg(len, data);
        inVal = 1'b1;
        tick();
        inVal = 1'b0;
        for (int i = 0; i < MSG_HEADER_WIDTH / 32; i++) hdrIn[i*32 +: 32] = $urandom();
        check("first_val0", NW'(if0.flit_out_val), NW'(1));
        check("first_val1", NW'(if1.flit_out_val), NW'(1));
        n0 = -1;
        bothIdle = 1'b0;
        for (int t = 1; t <= 400 && !bothIdle; t++) begin
            tick();
            if (n0 < 0 && if0.in_rdy) n0 = t;
            bothIdle = if0.in_rdy & if1.in_rdy;
        end
        check("idle_timeout", NW'(bothIdle), NW'(1));
    endtask

    function automatic logic [AXI4_DATA_WIDTH-1:0] patternData();
        logic [AXI4_DATA_WIDTH-1:0] d;
        for (int k = 0; k < PAYLOAD_LEN; k++) d[k*NW +: NW] = {8{8'(k * 17)}};
        return d;
    endfunction

    initial begin
        logic [AXI4_DATA_WIDTH-1:0] d;
        word_t swapExp;
        int len;

        // Reset state
        bpMode = 0;
        tick(); tick(); tick();
        check("rst_in_rdy0", NW'(if0.in_rdy), NW'(0));
        check("rst_in_rdy1", NW'(if1.in_rdy), NW'(0));
        check("rst_val0", NW'(if0.flit_out_val), NW'(0));
        check("rst_val1", NW'(if1.flit_out_val), NW'(0));
        check("rst_flit0", if0.flit_out, '0);
        check("rst_flit1", if1.flit_out, '0);
        rst = 1'b0;
        #1;
        check("post_rst_in_rdy0", NW'(if0.in_rdy), NW'(1));
        check("post_rst_in_rdy1", NW'(if1.in_rdy), NW'(1));

        // Length-8 message, no backpressure: 9 flits on consecutive cycles
        applyStimulus(8, patternData());
        checkOutput("len8_o0", 0);
        checkOutput("len8_o1", 1);
        check("len8_in_rdy_lat", NW'(n0), NW'(9));
        check("len8_span", NW'((stamp0.size() == 9) ? stamp0[8] - stamp0[0] : -1), NW'(8));

        // Zero-length messages back to back
        applyStimulus(0, patternData());
        checkOutput("len0a_o0", 0);
        checkOutput("len0a_o1", 1);
        check("len0_in_rdy_lat", NW'(n0), NW'(1));
        applyStimulus(0, patternData());
        checkOutput("len0b_o0", 0);
        checkOutput("len0b_o1", 1);

        // 1010 backpressure
        setMode(1);
        applyStimulus(8, patternData());
        checkOutput("bp_o0", 0);
        checkOutput("bp_o1", 1);
        setMode(0);

        // Reset in the middle of a message
        loadMsg(8, patternData());
        inVal = 1'b1;
        tick();
        inVal = 1'b0;
        for (int t = 0; t < 50 && got0.size() < 3; t++) tick();
        check("mid_flits_seen", NW'(got0.size()), NW'(3));
        rst = 1'b1;
        tick();
        check("mid_rst_val0", NW'(if0.flit_out_val), NW'(0));
        check("mid_rst_val1", NW'(if1.flit_out_val), NW'(0));
        check("mid_rst_in_rdy0", NW'(if0.in_rdy), NW'(0));
        rst = 1'b0;
        #1;
        check("mid_post_in_rdy0", NW'(if0.in_rdy), NW'(1));
        check("mid_post_in_rdy1", NW'(if1.in_rdy), NW'(1));
        applyStimulus(2, patternData());
        checkOutput("after_rst_o0", 0);
        checkOutput("after_rst_o1", 1);

        // Byte-order check on a non-palindromic data word
        d = patternData();
        d[7*NW +: NW] = 64'h0102030405060708;
        applyStimulus(1, d);
`ifdef NOC_AXI4_SER_SWAP_EN
        swapExp = 64'h0807060504030201;
`else
        swapExp = 64'h0102030405060708;
`endif
        check("swap_w7", (got0.size() > 1) ? got0[1] : 'x, swapExp);
        check("swap_hdr", (got0.size() > 0) ? got0[0] : 'x, curHdr[NW-1:0]);
        checkOutput("swap_o1", 1);

        // Random messages, lengths spanning zero through truncation, random readiness
        for (int m = 0; m < 24; m++) begin
            setMode(int'($urandom_range(0, 2)));
            for (int i = 0; i < AXI4_DATA_WIDTH / 32; i++) d[i*32 +: 32] = $urandom();
            len = (m == 0) ? 255 : int'($urandom_range(0, 15));
            applyStimulus(len, d);
            checkOutput($sformatf("rnd%0d_o0", m), 0);
            checkOutput($sformatf("rnd%0d_o1", m), 1);
            if (bpMode == 0) begin
                check($sformatf("rnd%0d_lat", m), NW'(n0), NW'(1 + ((len < PAYLOAD_LEN) ? len : PAYLOAD_LEN)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
